fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and flag generator for the async FIFO. It sits directly upstream of `fifomem`. It produces the write address and the `full` flag that gate storage into the memory. It also exports a Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray pointer into `clk` and derives occupancy, almost-full and a sticky overflow flag from it.

## Interface
- `ADDRSIZE`, 3: memory address width; FIFO depth = 2^ADDRSIZE; must be >= 2.
- `AFULL_THRESH`, 6: occupancy at or above which `almost_full` asserts; range 1..2^ADDRSIZE.

- `clk`  in  1  write-domain clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `winc`  in  1  write request for this cycle.
- `ovf_clr`  in  1  clears sticky `overflow`.
- `rptr_gray`  in  ADDRSIZE+1  read pointer, Gray-coded, asynchronous to `clk`.
- `waddr`  out  ADDRSIZE  write address to `fifomem`.
- `wptr`  out  ADDRSIZE+1  registered Gray write pointer to the read domain.
- `full`  out  1  registered full flag to `fifomem`; writes are blocked while high.
- `almost_full`  out  1  registered; occupancy >= `AFULL_THRESH`.
- `wcount`  out  ADDRSIZE+1  registered occupancy as seen from the write domain, 0..2^ADDRSIZE.
- `overflow`  out  1  sticky; set by a write attempt while full.

## Operation
- State:
  - `wbin`: ADDRSIZE+1-bit binary write pointer.
  - `wptr`: Gray copy of `wbin`.
  - `rq1`, `rq2`: two-flop synchronizer for `rptr_gray`.
  - Registered `full`, `almost_full`, `wcount`, `overflow`.
- Write acceptance: `wen = winc & ~full`.
- Next pointer: `wbinnext = wbin + wen`, modulo 2^(ADDRSIZE+1). `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- Address: `waddr = wbin[ADDRSIZE-1:0]`, combinational from the register. It wraps from 2^ADDRSIZE-1 to 0.
- Synchronizer: `rq1 <= rptr_gray; rq2 <= rq1`. Nothing other than `rq1` samples `rptr_gray`.
- Full test: `full <= (wgraynext == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]})`.
- Occupancy:
  - `rbin = gray2bin(rq2)`, where bit i is the XOR of `rq2[ADDRSIZE:i]`.
  - `wcount <= wbinnext - rbin`, modulo 2^(ADDRSIZE+1).
- Almost-full: `almost_full <= ((wbinnext - rbin) >= AFULL_THRESH)`. The comparison is unsigned, ADDRSIZE+1 bits.
- Overflow: `overflow <= (winc & full) | (overflow & ~ovf_clr)`. If a set and `ovf_clr` occur in the same cycle, the set wins.
- Write while full: the pointer does not move; only `overflow` is affected.
- Simultaneous `winc` and a read-pointer change: both are folded in on the same edge, through `wbinnext` and `rq2`.
- Reset (any time, including mid-burst): all registers clear to 0 immediately. Outputs go to `waddr`=0, `wptr`=0, `full`=0, `almost_full`=0, `wcount`=0, `overflow`=0. A write in flight during reset is discarded.

## Timing
- A write accepted at edge N: `waddr` and `wptr` show the new pointer after edge N.
- `fifomem` stores `wdata` at the old `waddr` on that same edge N.
- `full` asserts on the same edge that accepts the write filling the last slot. No write is accepted in the following cycle.
- A read-pointer change on `rptr_gray` reaches `rq2` after 2 edges. `full`, `wcount` and `almost_full` reflect it on the 3rd edge, so they deassert pessimistically late, never early.
- `wptr` is Gray-coded and registered: exactly one bit changes per accepted write, and it is glitch-free for the read-domain synchronizer.

## Test plan
- Reset: assert `rst_n`=0 mid-operation, asynchronously between edges -> all outputs 0 immediately, with no clock edge needed.
- Fill with `ADDRSIZE`=3, `rptr_gray`=0, 8 consecutive `winc`:
  - `waddr` sequence 0..7 then 0.
  - `wptr` sequence 0,1,3,2,6,7,5,4,12.
  - `almost_full`=1 after the 6th write.
  - `full`=1 and `wcount`=8 after the 8th.
- Write while full: 2 more `winc` -> `wptr` stays 12, `full` stays 1, `overflow`=1.
  - `overflow` holds with `winc`=0.
  - `ovf_clr` pulse -> `overflow`=0.
  - `winc`, `full` and `ovf_clr` all high in the same cycle -> `overflow` stays 1.
- Drain visibility: from full, set `rptr_gray`=1 (gray(1)) -> `full` falls and `wcount`=7 exactly on the 3rd edge after the change.
  - Then set `rptr_gray`=3 (gray(2)) -> `wcount`=6, `almost_full` still 1.
  - Then set `rptr_gray`=2 (gray(3)) -> `wcount`=5, `almost_full`=0.
- Wrap-around: 20 writes with `rptr_gray` tracking `wptr` 3 cycles behind:
  - `full` never asserts.
  - `wptr` passes through 8 (binary 15) back to 0.
  - `wcount` never exceeds 3.
- Simultaneous: `winc` on the same edge as `rq2` advancing -> `wcount` unchanged, `wptr` advances by one.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag generator for the async FIFO: binary+Gray write pointer, read-pointer sync, full/almost-full/occupancy/overflow.
// Latency: waddr/wptr/full update on the accepting edge; read-pointer moves are visible on the 3rd edge after they change.
// Backpressure: writes are dropped while full is high; a dropped write sets the sticky overflow flag.
module fifo_wptr_full #(
    parameter int ADDRSIZE     = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic                ovf_clr,
    input  logic [ADDRSIZE:0]   rptr_gray,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                full,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                overflow
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AF_TH = PW'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rq1;
    logic [ADDRSIZE:0] rq2;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] wdiff;
    logic              wen;
    logic              fullnext;

    assign wen       = winc & ~full;
    assign wbinnext  = wbin + PW'(wen);
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign fullnext = (wgraynext == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]});

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(rq2 >> i);
        end
    end

    assign wdiff = wbinnext - rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr        <= '0;
            rq1         <= '0;
            rq2         <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbinnext;
            wptr        <= wgraynext;
            rq1         <= rptr_gray;
            rq2         <= rq1;
            full        <= fullnext;
            almost_full <= (wdiff >= AF_TH);
            wcount      <= wdiff;
            overflow    <= (winc & full) | (overflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: occupancy-level reference model compared every cycle, plus directed literal checks.
module tb_fifo_wptr_full;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] rptr_gray = 4'd0;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    fifo_wptr_full #(.ADDRSIZE(3), .AFULL_THRESH(6)) dut (
        .clk(clk), .rst_n(rst_n), .winc(winc), .ovf_clr(ovf_clr), .rptr_gray(rptr_gray),
        .waddr(waddr), .wptr(wptr), .full(full), .almost_full(almost_full),
        .wcount(wcount), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: write count and read count as plain numbers, occupancy = difference.
    logic [3:0] m_wb = 4'd0, m_rd1 = 4'd0, m_rd2 = 4'd0, m_wc = 4'd0;
    logic       m_full = 1'b0, m_af = 1'b0, m_ovf = 1'b0;

    function automatic logic [3:0] nxt_wb(input logic w, input logic f, input logic [3:0] b);
        return (w && !f) ? b + 4'd1 : b;
    endfunction

    function automatic logic [3:0] occ(input logic w, input logic f, input logic [3:0] b, input logic [3:0] r);
        return nxt_wb(w, f, b) - r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wb <= 4'd0; m_rd1 <= 4'd0; m_rd2 <= 4'd0; m_wc <= 4'd0;
            m_full <= 1'b0; m_af <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_wb   <= nxt_wb(winc, m_full, m_wb);
            m_wc   <= occ(winc, m_full, m_wb, m_rd2);
            m_full <= (occ(winc, m_full, m_wb, m_rd2) == 4'd8);
            m_af   <= (occ(winc, m_full, m_wb, m_rd2) >= 4'd6);
            m_ovf  <= (winc && m_full) || (m_ovf && !ovf_clr);
            m_rd1  <= g2b(rptr_gray);
            m_rd2  <= m_rd1;
        end
    end

    always @(negedge clk) begin
        chk("waddr", waddr, m_wb[2:0]);
        chk("wptr", wptr, b2g(m_wb));
        chk("full", full, m_full);
        chk("almost_full", almost_full, m_af);
        chk("wcount", wcount, m_wc);
        chk("overflow", overflow, m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_waddr"}, waddr, 0);
        chk({nm, "_wptr"}, wptr, 0);
        chk({nm, "_full"}, full, 0);
        chk({nm, "_afull"}, almost_full, 0);
        chk({nm, "_wcount"}, wcount, 0);
        chk({nm, "_ovf"}, overflow, 0);
    endtask

    int         gtab[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
    int         maxwc;
    logic       sawfull;
    logic       saw8to0;
    logic [3:0] prevw;
    logic [3:0] r0;
    logic [3:0] wexp;
    logic [3:0] rb;

    initial begin
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;

        // Fill from empty.
        winc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_waddr", waddr, i);
            chk("fill_wptr", wptr, gtab[i]);
            tick();
            chk("fill_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill_waddr_wrap", waddr, 0);
        chk("fill_wptr_end", wptr, gtab[8]);
        chk("fill_full", full, 1);
        chk("fill_wcount", wcount, 8);

        // Writes while full.
        tick(); tick();
        chk("ovf_wptr", wptr, 12);
        chk("ovf_full", full, 1);
        chk("ovf_set", overflow, 1);
        winc = 1'b0;
        tick();
        chk("ovf_hold", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", overflow, 0);
        winc = 1'b1;
        tick();
        chk("ovf_set_wins", overflow, 1);
        winc = 1'b0; ovf_clr = 1'b0;

        // Drain visibility: only the 3rd edge after a read move shows it.
        rptr_gray = 4'd1;
        tick(); tick();
        chk("drain1_full_late", full, 1);
        tick();
        chk("drain1_full", full, 0);
        chk("drain1_wcount", wcount, 7);
        rptr_gray = 4'd3;
        repeat (3) tick();
        chk("drain2_wcount", wcount, 6);
        chk("drain2_afull", almost_full, 1);
        rptr_gray = 4'd2;
        repeat (3) tick();
        chk("drain3_wcount", wcount, 5);
        chk("drain3_afull", almost_full, 0);

        // Wrap-around with the reader tracking the write pointer.
        rptr_gray = wptr;
        repeat (3) tick();
        chk("wrap_settle", wcount, 0);
        maxwc = 0; sawfull = 1'b0; saw8to0 = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            prevw = wptr;
            rptr_gray = wptr;
            tick();
            if (int'(wcount) > maxwc) maxwc = int'(wcount);
            if (full) sawfull = 1'b1;
            if (prevw == 4'd8 && wptr == 4'd0) saw8to0 = 1'b1;
        end
        winc = 1'b0;
        chk("wrap_maxcount_le3", (maxwc <= 3) ? 1 : 0, 1);
        chk("wrap_full_never", sawfull, 0);
        chk("wrap_8_to_0", saw8to0, 1);
        rptr_gray = wptr;
        repeat (3) tick();

        // Read advance folds in on the same edge as a write.
        r0 = rptr_gray;
        winc = 1'b1;
        tick(); tick();
        winc = 1'b0;
        rptr_gray = b2g(g2b(r0) + 4'd1);
        tick(); tick();
        chk("simul_pre_wcount", wcount, 2);
        wexp = g2b(r0) + 4'd3;
        winc = 1'b1;
        tick();
        chk("simul_wcount", wcount, 2);
        chk("simul_wptr", wptr, b2g(wexp));
        winc = 1'b0;

        // Random traffic with a well-behaved reader, plus an async reset mid-run.
        rb = g2b(rptr_gray);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                winc = 1'b1;
                #3;
                rst_n = 1'b0;
                rb = 4'd0;
                rptr_gray = 4'd0;
                #1;
                chk_zero("async_reset");
                tick();
                rst_n = 1'b1;
            end
            winc = ($urandom % 4) != 0;
            ovf_clr = ($urandom % 8) == 0;
            if (($urandom % 3) == 0 && rb != m_wb) rb = rb + 4'd1;
            rptr_gray = b2g(rb);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
